// File: rtl/hwpe_dma_ctrl.sv
// rtl/hwpe_dma_ctrl.sv - fmap/kernel copy DMA controller; HWPE_DMA_KERN_EN compiles in the kernel phase
module hwpe_dma_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int NBANK  = 2,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_fmap_words,
  input  logic [ADDR_W-1:0] cfg_src_fmap_base,
  input  logic [ADDR_W-1:0] cfg_src_bank_stride,
  input  logic [ADDR_W-1:0] cfg_dst_fmap_base,
  input  logic [ADDR_W-1:0] cfg_dst_bank_stride,
  input  logic [LEN_W-1:0]  cfg_kern_words,
  input  logic [ADDR_W-1:0] cfg_src_kern_base,
  input  logic [ADDR_W-1:0] cfg_dst_kern_base,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              dma_wen,
  output logic [ADDR_W-1:0] dma_wa,
  output logic [DATA_W-1:0] dma_wd,
  input  logic              dma_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FMAP  = 3'd1,
`ifdef HWPE_DMA_KERN_EN
    S_KERN  = 3'd2,
`endif
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  fmap_words_q;
  logic [ADDR_W-1:0] src_stride_q;
  logic [ADDR_W-1:0] dst_stride_q;
  logic [BW-1:0]     bank_q;
  logic [LEN_W-1:0]  wrem_q;
  logic [ADDR_W-1:0] src_bank_q;
  logic [ADDR_W-1:0] dst_bank_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
`ifdef HWPE_DMA_KERN_EN
  logic [LEN_W-1:0]  kern_words_q;
  logic [ADDR_W-1:0] src_kern_q;
  logic [ADDR_W-1:0] dst_kern_q;
  logic [LEN_W-1:0]  kwrem_q;
`else
  logic              unused_kern_cfg;
  assign unused_kern_cfg = ^{cfg_kern_words, cfg_src_kern_base, cfg_dst_kern_base};
`endif

  // read return stage: dv_q marks src_rd_data valid this cycle, dv_addr_q is its destination
  logic              dv_q;
  logic [ADDR_W-1:0] dv_addr_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] buf_addr_q [2];
  logic [DATA_W-1:0] buf_data_q [2];

  logic       in_rd_phase;
  logic       issue;
  logic       fire;
  logic       pop_buf;
  logic       push;
  logic [1:0] pend;
  logic [1:0] left;

  // credit check: a read goes out only while buffered plus returning words stay below two
  always_comb begin
    pend        = cnt_q + {1'b0, dv_q};
    in_rd_phase = (state_q == S_FMAP);
`ifdef HWPE_DMA_KERN_EN
    if (state_q == S_KERN) in_rd_phase = 1'b1;
`endif
    issue   = in_rd_phase && (pend < 2'd2);
    fire    = dma_wen && dma_ready;
    pop_buf = fire && (cnt_q != 2'd0);
    push    = dv_q && !(fire && (cnt_q == 2'd0));
    left    = pend - {1'b0, fire};
  end

  assign src_rd_en   = issue;
  assign src_rd_addr = issue ? src_ptr_q : '0;
  assign dma_wen     = (cnt_q != 2'd0) || dv_q;
  assign dma_wa      = (cnt_q != 2'd0) ? buf_addr_q[0] : (dv_q ? dv_addr_q : '0);
  assign dma_wd      = (cnt_q != 2'd0) ? buf_data_q[0] : (dv_q ? src_rd_data : '0);
  assign cfg_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

  // transfer sequencer: latches the job, walks banks then kernel words, waits for writes to drain
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fmap_words_q <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      bank_q       <= '0;
      wrem_q       <= '0;
      src_bank_q   <= '0;
      dst_bank_q   <= '0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
`ifdef HWPE_DMA_KERN_EN
      kern_words_q <= '0;
      src_kern_q   <= '0;
      dst_kern_q   <= '0;
      kwrem_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            fmap_words_q <= cfg_fmap_words;
            src_stride_q <= cfg_src_bank_stride;
            dst_stride_q <= cfg_dst_bank_stride;
            bank_q       <= '0;
            wrem_q       <= cfg_fmap_words;
            src_bank_q   <= cfg_src_fmap_base;
            dst_bank_q   <= cfg_dst_fmap_base;
            src_ptr_q    <= cfg_src_fmap_base;
            dst_ptr_q    <= cfg_dst_fmap_base;
`ifdef HWPE_DMA_KERN_EN
            kern_words_q <= cfg_kern_words;
            src_kern_q   <= cfg_src_kern_base;
            dst_kern_q   <= cfg_dst_kern_base;
            kwrem_q      <= cfg_kern_words;
`endif
            if (cfg_fmap_words != '0) begin
              state_q <= S_FMAP;
            end
`ifdef HWPE_DMA_KERN_EN
            else if (cfg_kern_words != '0) begin
              state_q   <= S_KERN;
              src_ptr_q <= cfg_src_kern_base;
              dst_ptr_q <= cfg_dst_kern_base;
            end
`endif
            else begin
              state_q <= S_FIN;
            end
          end
        end
        S_FMAP: begin
          if (issue) begin
            if (wrem_q == LEN_W'(1)) begin
              if (bank_q == LAST_BANK) begin
`ifdef HWPE_DMA_KERN_EN
                if (kern_words_q != '0) begin
                  state_q   <= S_KERN;
                  src_ptr_q <= src_kern_q;
                  dst_ptr_q <= dst_kern_q;
                end else begin
                  state_q <= S_DRAIN;
                end
`else
                state_q <= S_DRAIN;
`endif
              end else begin
                bank_q     <= bank_q + 1'b1;
                wrem_q     <= fmap_words_q;
                src_bank_q <= src_bank_q + src_stride_q;
                dst_bank_q <= dst_bank_q + dst_stride_q;
                src_ptr_q  <= src_bank_q + src_stride_q;
                dst_ptr_q  <= dst_bank_q + dst_stride_q;
              end
            end else begin
              wrem_q    <= wrem_q - 1'b1;
              src_ptr_q <= src_ptr_q + STEP;
              dst_ptr_q <= dst_ptr_q + STEP;
            end
          end
        end
`ifdef HWPE_DMA_KERN_EN
        S_KERN: begin
          if (issue) begin
            if (kwrem_q == LEN_W'(1)) begin
              state_q <= S_DRAIN;
            end else begin
              kwrem_q   <= kwrem_q - 1'b1;
              src_ptr_q <= src_ptr_q + STEP;
              dst_ptr_q <= dst_ptr_q + STEP;
            end
          end
        end
`endif
        S_DRAIN: begin
          if (left == 2'd0) state_q <= S_FIN;
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // read return and 2-entry skid: returning data bypasses straight to the write port when the buffer is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q          <= 1'b0;
      dv_addr_q     <= '0;
      cnt_q         <= 2'd0;
      buf_addr_q[0] <= '0;
      buf_addr_q[1] <= '0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
    end else begin
      dv_q <= issue;
      if (issue) dv_addr_q <= dst_ptr_q;
      if (pop_buf) begin
        buf_addr_q[0] <= buf_addr_q[1];
        buf_data_q[0] <= buf_data_q[1];
      end
      if (push) begin
        if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_buf)) begin
          buf_addr_q[0] <= dv_addr_q;
          buf_data_q[0] <= src_rd_data;
        end else begin
          buf_addr_q[1] <= dv_addr_q;
          buf_data_q[1] <= src_rd_data;
        end
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_buf};
    end
  end

endmodule

// File: doc/hwpe_dma_ctrl.md
HWPE_DMA_CTRL -- requirements
Module: hwpe_dma_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16 (matches HWPE_ADDR_WIDTH), meaning source and destination byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning transfer word width; the address step per word is DATA_W/8.
REQ-003 SHALL have parameter NBANK, default 2, legal range 1..8, meaning number of fmap SRAM banks.
REQ-004 SHALL have parameter LEN_W, default 16, meaning word-count width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): start handshake; a start is accepted when both are high.
REQ-008 SHALL have inputs cfg_fmap_words (LEN_W, words per bank), cfg_src_fmap_base, cfg_src_bank_stride, cfg_dst_fmap_base and cfg_dst_bank_stride (each ADDR_W).
REQ-009 SHALL have inputs cfg_kern_words (LEN_W), cfg_src_kern_base and cfg_dst_kern_base (ADDR_W each).
REQ-010 SHALL have outputs src_rd_en (1) and src_rd_addr (ADDR_W), and input src_rd_data (DATA_W); read data is valid exactly 1 cycle after src_rd_en.
REQ-011 SHALL have outputs dma_wen (1), dma_wa (ADDR_W) and dma_wd (DATA_W), and input dma_ready (1); a write completes when dma_wen and dma_ready are both high.
REQ-012 SHALL have outputs busy (1) and done (1; a 1-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, FMAP, KERN, DRAIN and FIN; on an accepted start, IDLE goes to FMAP.
REQ-014 SHALL latch all cfg_* inputs on start acceptance; cfg changes during a transfer SHALL have no effect.
REQ-015 SHALL assert cfg_ready only in IDLE; cfg_valid in any other state SHALL be ignored.
REQ-016 In FMAP, SHALL issue, for b=0..NBANK-1 and i=0..cfg_fmap_words-1, the source read at src_fmap_base+b*src_bank_stride+i*8 and the write to dst_fmap_base+b*dst_bank_stride+i*8.
REQ-017 SHALL process banks in ascending order, with words in ascending order within a bank.
REQ-018 After the last fmap read is issued, SHALL go to KERN and issue cfg_kern_words reads from src_kern_base+i*8, each written to dst_kern_base+i*8.
REQ-019 SHALL go to DRAIN after the final read issue, and to FIN when all writes have completed.
REQ-020 FIN SHALL pulse done for 1 cycle, then return to IDLE.
REQ-021 SHALL compute addresses modulo 2^ADDR_W (wrap, no error).
REQ-022 SHALL hold dma_wa and dma_wd stable while dma_wen is high and dma_ready is low.
REQ-023 SHALL use a 2-entry skid buffer for returning read data.
REQ-024 SHALL issue a read only when the number of buffered words plus in-flight reads is less than 2; no data is ever dropped.
REQ-025 With dma_ready held at 1, throughput SHALL be 1 word/cycle; the first dma_wen SHALL occur 2 cycles after start acceptance.
REQ-026 If cfg_fmap_words==0, FMAP SHALL be skipped; if cfg_kern_words==0, KERN SHALL be skipped.
REQ-027 If both counts are 0, done SHALL pulse 1 cycle after acceptance and no reads or writes SHALL occur.
REQ-028 busy SHALL be high in every state except IDLE.

Reset
REQ-029 rst SHALL force IDLE, clear all counters and the skid buffer, and cancel in-flight reads (their data is discarded).
REQ-030 Output values during and after reset SHALL be: cfg_ready=1, busy=0, done=0, src_rd_en=0, dma_wen=0, src_rd_addr=0, dma_wa=0, dma_wd=0.
REQ-031 rst asserted mid-transfer SHALL abort with no done pulse; a new start SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-032 The macro HWPE_DMA_KERN_EN SHALL control the kernel phase.
REQ-033 With HWPE_DMA_KERN_EN defined, the KERN phase SHALL be compiled in as specified above.
REQ-034 Without HWPE_DMA_KERN_EN, the KERN state and its counter SHALL be absent, the kern cfg inputs SHALL be ignored, FMAP SHALL go directly to DRAIN, and the ports SHALL remain unchanged.

Verification
REQ-035 Run NBANK=2, fmap_words=110, src_bank_stride=640, dst_fmap_base=0, dst_bank_stride=0x1000, kern_words=576, dst_kern_base=0x2000, dma_ready=1 -> 796 writes in order 0x0..0x368, 0x1000..0x1368, 0x2000..0x31F8; done is 1 pulse; data matches source.
REQ-036 Same configuration, with dma_ready toggled pseudo-randomly at 50% -> identical write sequence, no lost or duplicated words, dma_wa/dma_wd stable while stalled.
REQ-037 fmap_words=0, kern_words=0 -> done 1 cycle after acceptance; src_rd_en and dma_wen never asserted.
REQ-038 rst asserted at write 50, then a new start issued the cycle after rst falls -> no done for the aborted run; the second run is complete and correct from address 0.
REQ-039 dst_fmap_base=0xFFF8, fmap_words=3, NBANK=1 (ADDR_W=16) -> write addresses 0xFFF8, 0x0000, 0x0008.
REQ-040 cfg_valid held high during a transfer, with altered cfg inputs -> ignored; the transfer uses the latched values; the next start is accepted in IDLE after done.
